burst_cfg_sequencer: RTL and testbench

Upstream control stage for `gated_burst_divider`. Accepts new burst settings (M1, M2, X) over a valid/ready handshake and a software run request. Applies each setting change through a fixed disable → drain → load → setup → enable sequence, so the divider's synchronised enable is never high while its settings change. Drives the divider's `enable_async`, `m1_value`, `m2_value` and `m1_repeat_limit` inputs directly.

---
 rtl/burst_pkg.sv | 21 ++
 rtl/burst_wait_timer.sv | 26 ++
 rtl/burst_cfg_sequencer.sv | 153 +++++++++++++++
 tb/tb_burst_cfg_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared types and default constants for the burst configuration sequencer.
package burst_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SETUP = 3'd4
    } burst_seq_state_t;

    localparam int unsigned M_WIDTH_DEF      = 10;
    localparam int unsigned X_WIDTH_DEF      = 5;
    localparam int unsigned DRAIN_CYCLES_DEF = 5;
    localparam int unsigned SETUP_CYCLES_DEF = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_wait_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded wait.
module burst_wait_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt <= W'(1));

endmodule

// File: rtl/burst_cfg_sequencer.sv
// Sequences burst setting changes for gated_burst_divider: disable, drain, load, setup, enable.
// Optional BURST_CFG_SKIP_SAME_EN: identical settings offered while running skip the sequence.
module burst_cfg_sequencer
    import burst_pkg::*;
#(
    parameter int unsigned M_WIDTH      = M_WIDTH_DEF,
    parameter int unsigned X_WIDTH      = X_WIDTH_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_req,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [M_WIDTH-1:0] cfg_m1,
    input  logic [M_WIDTH-1:0] cfg_m2,
    input  logic [X_WIDTH-1:0] cfg_x,
    output logic [M_WIDTH-1:0] m1_value,
    output logic [M_WIDTH-1:0] m2_value,
    output logic [X_WIDTH-1:0] m1_repeat_limit,
    output logic               enable_async,
    output logic               busy,
    output logic               cfg_applied
);

    localparam int unsigned CW = $clog2(max_u(DRAIN_CYCLES, SETUP_CYCLES) + 1);

    burst_seq_state_t state, next_state;

    logic [M_WIDTH-1:0] shadow_m1, shadow_m2;
    logic [X_WIDTH-1:0] shadow_x;
    logic               pending;
    logic               from_run;
    logic               xfer;
    logic               same;
    logic               skip;
    logic               timer_load;
    logic [CW-1:0]      timer_value;
    logic               wait_done;

    assign cfg_ready = (state == ST_OFF) || (state == ST_RUN);
    assign xfer      = cfg_valid && cfg_ready;

`ifdef BURST_CFG_SKIP_SAME_EN
    assign same = (cfg_m1 == m1_value) && (cfg_m2 == m2_value) && (cfg_x == m1_repeat_limit);
`else
    assign same = 1'b0;
`endif

    assign skip = xfer && (state == ST_RUN) && same;

    burst_wait_timer #(.W(CW)) u_wait (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (wait_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_OFF;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus wait-timer load on entry to DRAIN or SETUP.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_OFF: begin
                if (xfer) begin
                    next_state = ST_LOAD;
                end else if (run_req) begin
                    next_state = ST_SETUP;
                end
            end
            ST_RUN: begin
                if ((xfer && !skip) || !run_req) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wait_done) begin
                    next_state = pending ? ST_LOAD : ST_OFF;
                end
            end
            ST_LOAD: begin
                next_state = from_run ? ST_SETUP : ST_OFF;
            end
            ST_SETUP: begin
                if (wait_done) begin
                    next_state = run_req ? ST_RUN : ST_OFF;
                end
            end
            default: begin
                next_state = ST_OFF;
            end
        endcase
        if (next_state != state) begin
            if (next_state == ST_DRAIN) begin
                timer_load  = 1'b1;
                timer_value = CW'(DRAIN_CYCLES);
            end else if (next_state == ST_SETUP) begin
                timer_load  = 1'b1;
                timer_value = CW'(SETUP_CYCLES);
            end
        end
    end

    // Shadow capture, sequence bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_m1       <= '0;
            shadow_m2       <= '0;
            shadow_x        <= '0;
            pending         <= 1'b0;
            from_run        <= 1'b0;
            m1_value        <= '0;
            m2_value        <= '0;
            m1_repeat_limit <= '0;
            enable_async    <= 1'b0;
            busy            <= 1'b0;
            cfg_applied     <= 1'b0;
        end else begin
            if (xfer) begin
                shadow_m1 <= cfg_m1;
                shadow_m2 <= cfg_m2;
                shadow_x  <= cfg_x;
            end
            if (xfer && !skip) begin
                pending  <= 1'b1;
                from_run <= (state == ST_RUN);
            end else if (state == ST_LOAD) begin
                pending <= 1'b0;
            end
            if (state == ST_LOAD) begin
                m1_value        <= shadow_m1;
                m2_value        <= shadow_m2;
                m1_repeat_limit <= shadow_x;
            end
            enable_async <= (next_state == ST_RUN);
            busy         <= (next_state == ST_DRAIN) || (next_state == ST_LOAD) ||
                            (next_state == ST_SETUP);
            cfg_applied  <= (state == ST_LOAD) || skip;
        end
    end

endmodule

// File: tb/tb_burst_cfg_sequencer.sv
// Directed table-driven bench for burst_cfg_sequencer (default parameters).
module tb_burst_cfg_sequencer;

    logic       clk;
    logic       reset_n;
    logic       run_req;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] cfg_m1, cfg_m2;
    logic [4:0] cfg_x;
    logic [9:0] m1_value, m2_value;
    logic [4:0] m1_repeat_limit;
    logic       enable_async;
    logic       busy;
    logic       cfg_applied;

    int checks = 0;
    int errors = 0;

    burst_cfg_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .run_req         (run_req),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_m1          (cfg_m1),
        .cfg_m2          (cfg_m2),
        .cfg_x           (cfg_x),
        .m1_value        (m1_value),
        .m2_value        (m2_value),
        .m1_repeat_limit (m1_repeat_limit),
        .enable_async    (enable_async),
        .busy            (busy),
        .cfg_applied     (cfg_applied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       valid;
        logic [9:0] m1;
        logic [9:0] m2;
        logic [4:0] x;
        logic       en;
        logic [9:0] em1;
        logic [9:0] em2;
        logic [4:0] ex;
        logic       rdy;
        logic       bsy;
        logic       app;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [9:0] a, input logic [9:0] b,
                       input logic [4:0] c, input logic e, input logic [9:0] ea,
                       input logic [9:0] eb, input logic [4:0] ec, input logic rd,
                       input logic bs, input logic ap);
        vec_t t;
        t.run = r; t.valid = v; t.m1 = a; t.m2 = b; t.x = c;
        t.en = e; t.em1 = ea; t.em2 = eb; t.ex = ec; t.rdy = rd; t.bsy = bs; t.app = ap;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e, input logic [9:0] a,
                              input logic [9:0] b, input logic [4:0] c, input logic rd,
                              input logic bs, input logic ap);
        check({tag, ".enable"}, 32'(enable_async), 32'(e));
        check({tag, ".m1"}, 32'(m1_value), 32'(a));
        check({tag, ".m2"}, 32'(m2_value), 32'(b));
        check({tag, ".x"}, 32'(m1_repeat_limit), 32'(c));
        check({tag, ".ready"}, 32'(cfg_ready), 32'(rd));
        check({tag, ".busy"}, 32'(busy), 32'(bs));
        check({tag, ".applied"}, 32'(cfg_applied), 32'(ap));
    endtask

    // Drive one cycle of inputs, clock once, sample shortly after the edge.
    task automatic step(input logic r, input logic v, input logic [9:0] a, input logic [9:0] b,
                        input logic [4:0] c);
        run_req = r; cfg_valid = v; cfg_m1 = a; cfg_m2 = b; cfg_x = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; run_req = 1'b0; cfg_valid = 1'b0;
        cfg_m1 = '0; cfg_m2 = '0; cfg_x = '0;

        // Start/stop from reset, load in OFF, update while running (offer during DRAIN ignored),
        // then transfer coinciding with run_req fall.
        add(0,0,0,0,0,      0,0,0,0,     1,0,0);
        for (int i = 0; i < 2; i++) add(1,0,0,0,0, 0,0,0,0, 0,1,0);
        add(1,0,0,0,0,      1,0,0,0,     1,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0,0,0, 0,1,0);
        add(0,0,0,0,0,      0,0,0,0,     1,0,0);
        add(0,1,2,10,4,     0,0,0,0,     0,1,0);
        add(0,0,0,0,0,      0,2,10,4,    1,0,1);
        add(0,0,0,0,0,      0,2,10,4,    1,0,0);
        for (int i = 0; i < 2; i++) add(1,0,0,0,0, 0,2,10,4, 0,1,0);
        add(1,0,0,0,0,      1,2,10,4,    1,0,0);
        add(1,1,1,20,8,     0,2,10,4,    0,1,0);
        add(1,0,0,0,0,      0,2,10,4,    0,1,0);
        add(1,1,0,1023,31,  0,2,10,4,    0,1,0);
        for (int i = 0; i < 2; i++) add(1,0,0,0,0, 0,2,10,4, 0,1,0);
        add(1,0,0,0,0,      0,2,10,4,    0,1,0);
        add(1,0,0,0,0,      0,1,20,8,    0,1,1);
        add(1,0,0,0,0,      0,1,20,8,    0,1,0);
        add(1,0,0,0,0,      1,1,20,8,    1,0,0);
        add(1,0,0,0,0,      1,1,20,8,    1,0,0);
        add(0,1,0,1023,31,  0,1,20,8,    0,1,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0,0, 0,1,20,8, 0,1,0);
        add(0,0,0,0,0,      0,1,20,8,    0,1,0);
        add(0,0,0,0,0,      0,0,1023,31, 0,1,1);
        add(0,0,0,0,0,      0,0,1023,31, 0,1,0);
        add(0,0,0,0,0,      0,0,1023,31, 1,0,0);
        add(0,0,0,0,0,      0,0,1023,31, 1,0,0);

        #12;
        check_outs("reset", 0, 0, 0, 0, 1, 0, 0);
        #10 reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].run, vecs[i].valid, vecs[i].m1, vecs[i].m2, vecs[i].x);
            check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].em1, vecs[i].em2,
                       vecs[i].ex, vecs[i].rdy, vecs[i].bsy, vecs[i].app);
        end

        // Reset asserted in the middle of DRAIN clears everything at once.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check_outs("mr_run", 1, 0, 1023, 31, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_outs("mr_drain", 0, 0, 1023, 31, 0, 1, 0);
        #1 reset_n = 1'b0;
        #1 check_outs("mr_async", 0, 0, 0, 0, 1, 0, 0);
        #2 reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        check_outs("mr_off", 0, 0, 0, 0, 1, 0, 0);

        // Identical settings offered while running.
        step(0, 1, 5, 6, 7);
        step(0, 0, 0, 0, 0);
        check_outs("same_load", 0, 5, 6, 7, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check_outs("same_run", 1, 5, 6, 7, 1, 0, 0);
        step(1, 1, 5, 6, 7);
`ifdef BURST_CFG_SKIP_SAME_EN
        check_outs("same_t1", 1, 5, 6, 7, 1, 0, 1);
        step(1, 0, 0, 0, 0);
        check_outs("same_t2", 1, 5, 6, 7, 1, 0, 0);
`else
        check_outs("same_t1", 0, 5, 6, 7, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        check_outs("same_t2", 0, 5, 6, 7, 0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
